// File: rtl/uart_pkg.sv
// Shared UART types and constants for the transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_FRAME_BITS = 10;
  localparam int unsigned DEFAULT_CLK_DIV = 434;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLK_DIV-1 while run is high and flags the last count.
module uart_baud_gen #(
  parameter int unsigned CLK_DIV = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int unsigned CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST    = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] PRELAST = CW'(CLK_DIV - 2);

  logic [CW-1:0] count;

  // Counter with wrap; tick is registered so it is high exactly while count == LAST.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (clear || !run) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
      tick <= (count == PRELAST);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one 8N1 UART transmitter shared by NUM_REQ byte requesters.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV,
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       iENABLE,
  input  logic [NUM_REQ-1:0]         iREQ_VALID,
  input  logic [8*NUM_REQ-1:0]       iREQ_DATA,
  output logic [NUM_REQ-1:0]         oREQ_READY,
  output logic [$clog2(NUM_REQ)-1:0] oGRANT_ID,
  output logic                       oBUSY,
  output logic                       oTX_DATA
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  uart_state_e               state;
  logic [IDW-1:0]            last_grant;
  logic [IDW-1:0]            winner;
  logic                      any_valid;
  logic                      accept;
  logic                      tick;
  logic [UART_DATA_BITS-1:0] shreg;
  logic [2:0]                bit_idx;

  // Round-robin search starting one past the last accepted requester.
  always_comb begin
    logic [IDW-1:0] cand;
    cand      = '0;
    winner    = '0;
    any_valid = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IDW'((32'(last_grant) + i) % NUM_REQ);
      if (!any_valid && iREQ_VALID[cand]) begin
        any_valid = 1'b1;
        winner    = cand;
      end
    end
  end

  // Accept only from IDLE, and never while reset is held.
  assign accept = reset && (state == IDLE) && iENABLE && any_valid;

  // One-hot ready pulse coincides with the accepting cycle so data is sampled on that edge.
  always_comb begin
    oREQ_READY = '0;
    if (accept) begin
      oREQ_READY[winner] = 1'b1;
    end
  end

  uart_baud_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .run   (state != IDLE),
    .tick  (tick)
  );

  // Frame sequencer: start bit, eight data bits LSB first, stop bit; all line outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      oTX_DATA   <= 1'b1;
      oBUSY      <= 1'b0;
      oGRANT_ID  <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      last_grant <= IDW'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= START;
            shreg      <= iREQ_DATA[{winner, 3'b000} +: UART_DATA_BITS];
            oGRANT_ID  <= winner;
            last_grant <= winner;
            oTX_DATA   <= 1'b0;
            oBUSY      <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            state    <= DATA;
            bit_idx  <= '0;
            oTX_DATA <= shreg[0];
            shreg    <= shreg >> 1;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
              state    <= STOP;
              oTX_DATA <= 1'b1;
            end else begin
              bit_idx  <= bit_idx + 3'd1;
              oTX_DATA <= shreg[0];
              shreg    <= shreg >> 1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            state <= IDLE;
            oBUSY <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter at CLK_DIV=4, NUM_REQ=4.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        reset;
  logic        iENABLE;
  logic [3:0]  iREQ_VALID;
  logic [31:0] iREQ_DATA;
  logic [3:0]  oREQ_READY;
  logic [1:0]  oGRANT_ID;
  logic        oBUSY;
  logic        oTX_DATA;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int prev_acc = 0;
  int c0 = 0;

  uart_tx_arbiter #(
    .CLK_DIV (4),
    .NUM_REQ (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .iENABLE    (iENABLE),
    .iREQ_VALID (iREQ_VALID),
    .iREQ_DATA  (iREQ_DATA),
    .oREQ_READY (oREQ_READY),
    .oGRANT_ID  (oGRANT_ID),
    .oBUSY      (oBUSY),
    .oTX_DATA   (oTX_DATA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Poll (bounded) for a ready pulse and require it to be the given requester.
  task automatic wait_ready(input int id);
    int n;
    n = 0;
    #1;
    while (oREQ_READY == 4'b0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    acc_cyc = cyc;
    check("ready_onehot", 32'(oREQ_READY), 32'(4'b0001 << id));
  endtask

  // Check all 40 cycles of a frame; at frame step 'step' apply new inputs.
  task automatic frame_check(input logic [7:0] b, input int gid, input int step,
                             input logic [3:0] nvalid, input logic [31:0] ndata,
                             input logic nen);
    logic e;
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (k == 0) e = 1'b0;
        else if (k == 9) e = 1'b1;
        else e = b[k-1];
        check("tx_bit", 32'(oTX_DATA), 32'(e));
        check("busy_frame", 32'(oBUSY), 32'd1);
        check("grant_id", 32'(oGRANT_ID), 32'(gid));
        check("ready_in_frame", 32'(oREQ_READY), 32'd0);
        if (k * 4 + c == step) begin
          iREQ_VALID = nvalid;
          iREQ_DATA  = ndata;
          iENABLE    = nen;
        end
      end
    end
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    #1;
    check({tag, "_busy"}, 32'(oBUSY), 32'd0);
    check({tag, "_tx"}, 32'(oTX_DATA), 32'd1);
    check({tag, "_ready"}, 32'(oREQ_READY), 32'd0);
  endtask

  initial begin
    reset      = 1'b0;
    iENABLE    = 1'b0;
    iREQ_VALID = 4'b0;
    iREQ_DATA  = 32'b0;

    // Reset state, including no ready while requests are pending under reset.
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(oTX_DATA), 32'd1);
    check("rst_busy", 32'(oBUSY), 32'd0);
    check("rst_grant", 32'(oGRANT_ID), 32'd0);
    iENABLE    = 1'b1;
    iREQ_VALID = 4'b1111;
    #1;
    check("rst_ready", 32'(oREQ_READY), 32'd0);
    @(negedge clk);
    iREQ_VALID = 4'b0;

    // Single request from req0 with 0xA5.
    reset      = 1'b1;
    iREQ_VALID = 4'b0001;
    iREQ_DATA  = 32'h0000_00A5;
    wait_ready(0);
    frame_check(8'hA5, 0, 0, 4'b0000, 32'h0000_00A5, 1'b1);
    idle_check("single_end");

    // Data stability: byte changes right after ready, latched 0x3C goes out.
    iREQ_VALID = 4'b0100;
    iREQ_DATA  = 32'h003C_0000;
    wait_ready(2);
    frame_check(8'h3C, 2, 0, 4'b0000, 32'h00FF_0000, 1'b1);
    idle_check("stable_end");

    // Enable dropped at cycle 10 of a frame; pending req3 is held off until it returns.
    iREQ_VALID = 4'b0010;
    iREQ_DATA  = 32'hC300_9600;
    wait_ready(1);
    frame_check(8'h96, 1, 9, 4'b1000, 32'hC300_9600, 1'b0);
    repeat (3) idle_check("en_off");
    @(negedge clk);
    iENABLE = 1'b1;
    c0 = cyc;
    wait_ready(3);
    check("en_latency", 32'(acc_cyc - c0), 32'd0);
    frame_check(8'hC3, 3, 0, 4'b0000, 32'hC300_9600, 1'b1);
    idle_check("en_end");

    // Reset during DATA bit 3 of a 0x37 frame.
    iREQ_VALID = 4'b0001;
    iREQ_DATA  = 32'h0000_0037;
    wait_ready(0);
    for (int s = 0; s < 18; s++) begin
      @(negedge clk);
      if (s == 0) iREQ_VALID = 4'b0;
    end
    check("pre_rst_tx", 32'(oTX_DATA), 32'd0);
    check("pre_rst_busy", 32'(oBUSY), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_tx", 32'(oTX_DATA), 32'd1);
    check("async_rst_busy", 32'(oBUSY), 32'd0);
    check("async_rst_ready", 32'(oREQ_READY), 32'd0);
    @(negedge clk);

    // Round robin with all four valid: 0,1,2,3,0 spaced 41 cycles.
    reset      = 1'b1;
    iREQ_VALID = 4'b1111;
    iREQ_DATA  = 32'h8144_2211;
    wait_ready(0);
    prev_acc = acc_cyc;
    frame_check(8'h11, 0, 0, 4'b1111, 32'h8144_2211, 1'b1);
    wait_ready(1);
    check("rr_space01", 32'(acc_cyc - prev_acc), 32'd41);
    prev_acc = acc_cyc;
    frame_check(8'h22, 1, 0, 4'b1111, 32'h8144_2211, 1'b1);
    wait_ready(2);
    check("rr_space12", 32'(acc_cyc - prev_acc), 32'd41);
    prev_acc = acc_cyc;
    frame_check(8'h44, 2, 0, 4'b1111, 32'h8144_2211, 1'b1);
    wait_ready(3);
    check("rr_space23", 32'(acc_cyc - prev_acc), 32'd41);
    prev_acc = acc_cyc;
    frame_check(8'h81, 3, 0, 4'b1111, 32'h8144_2211, 1'b1);
    wait_ready(0);
    check("rr_space30", 32'(acc_cyc - prev_acc), 32'd41);
    prev_acc = acc_cyc;

    // Skip: req1 drops mid-frame while req3 stays valid, so req3 wins next.
    frame_check(8'h11, 0, 20, 4'b1000, 32'h8144_2211, 1'b1);
    wait_ready(3);
    check("skip_space", 32'(acc_cyc - prev_acc), 32'd41);
    frame_check(8'h81, 3, 0, 4'b0000, 32'h8144_2211, 1'b1);
    idle_check("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter CLK_DIV, default 434; clk cycles per bit (50 MHz / 115200), legal range 2..65535.
REQ-002 Parameter NUM_REQ, default 4; number of byte requesters sharing the transmitter, legal range 2..8.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 iENABLE  in  1  1 = new frames may start; 0 = current frame completes, then no further accepts.
REQ-006 iREQ_VALID  in  NUM_REQ  per-requester byte-pending flag.
REQ-007 iREQ_DATA  in  8*NUM_REQ  requester k byte at bits [8k+7:8k].
REQ-008 oREQ_READY  out  NUM_REQ  one-hot, one-cycle accept pulse to the winning requester.
REQ-009 oGRANT_ID  out  clog2(NUM_REQ)  index of the requester whose frame is on the line; holds the last value when idle.
REQ-010 oBUSY  out  1  1 in every state except IDLE.
REQ-011 oTX_DATA  out  1  serial line, idle high.

Function
REQ-012 States: IDLE, START, DATA, STOP; a 3-bit bit index counts within DATA.
REQ-013 IDLE: when iENABLE=1 and any iREQ_VALID=1, select the winner, pulse its oREQ_READY, latch its byte into the shift register, and move to START, all in that cycle.
REQ-014 Arbitration: round-robin; search starts at last_grant+1 modulo NUM_REQ; first asserted valid wins.
REQ-015 last_grant updates only on accept.
REQ-016 Handshake: a requester holds valid and data stable until its ready pulse; data is sampled only on the ready cycle; later data changes do not affect the frame.
REQ-017 Requesters that drop valid before winning are simply skipped; no error is raised.
REQ-018 Baud counter: clears on accept, counts 0..CLK_DIV-1 while not IDLE; tick = (count == CLK_DIV-1); counter wraps to 0 on tick.
REQ-019 oTX_DATA is 0 from the cycle after accept through the START tick, giving exactly CLK_DIV cycles of start bit.
REQ-020 START tick -> DATA with bit index 0.
REQ-021 DATA drives the latched byte LSB first, CLK_DIV cycles per bit.
REQ-022 On the tick with bit index 7, move to STOP; otherwise increment the bit index.
REQ-023 STOP drives oTX_DATA=1 for CLK_DIV cycles; on its tick, move to IDLE.
REQ-024 Frame = 10*CLK_DIV cycles; minimum accept-to-accept period = 10*CLK_DIV+1 cycles, since IDLE lasts at least one cycle.
REQ-025 iENABLE falling mid-frame: the frame completes unchanged; IDLE then holds with no ready pulses.
REQ-026 In IDLE, oTX_DATA=1 and the baud counter is held at 0.
REQ-027 oTX_DATA is registered and glitch-free.
REQ-028 oREQ_READY is never asserted outside IDLE and never has more than one bit set.

Reset
REQ-029 While reset=0: state=IDLE, oTX_DATA=1, oBUSY=0, oREQ_READY=0, oGRANT_ID=0, baud counter=0, bit index=0, shift register=0, last_grant=NUM_REQ-1 (requester 0 wins first).
REQ-030 Reset asserted mid-frame: oTX_DATA goes high immediately (asynchronous); the partial frame is abandoned and not resent.
REQ-031 First accept may occur on the first clk edge after reset deasserts.

Structure
REQ-032 Shared package uart_pkg holds: state enum (IDLE/START/DATA/STOP), UART_DATA_BITS=8, UART_FRAME_BITS=10, DEFAULT_CLK_DIV=434.
REQ-033 The baud counter is a sub-module, uart_baud_gen (inputs clk, reset, clear, run; output tick); the arbiter FSM stays in uart_tx_arbiter.

Verification (CLK_DIV=4, NUM_REQ=4)
REQ-034 Single request: req0 valid with 8'hA5 -> ready0 pulses one cycle; line = 0,1,0,1,0,0,1,0,1,1 at 4 cycles per bit; oBUSY high for 40 cycles.
REQ-035 Round-robin: all four valid continuously -> grant order 0,1,2,3,0; accepts spaced exactly 41 cycles; oGRANT_ID matches each frame.
REQ-036 Data stability: req2 sends 8'h3C; iREQ_DATA changes to 8'hFF the cycle after ready -> 8'h3C is transmitted.
REQ-037 Enable: iENABLE drops at cycle 10 of a frame -> frame completes at 40 cycles; no ready pulses while iENABLE=0; the next frame starts 1 cycle after iENABLE returns.
REQ-038 Reset mid-frame: reset asserted during DATA bit 3 -> oTX_DATA=1 and oBUSY=0 without waiting for clk; after release, req0 wins the first arbitration.
REQ-039 Skip: req1 valid, drops before its turn while req3 is valid -> req3 granted; ready1 never pulses.
